// File: rtl/gray_dec_tracker.sv
// Gray-to-binary decoder with sample tracking: captures a Gray word on a strobe,
// decodes it, classifies it against the previous sample and counts illegal jumps.
module gray_dec_tracker #(
  parameter int W     = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample,
  input  logic [W-1:0]     gray_in,
  input  logic             clear,
  output logic [W-1:0]     bin_out,
  output logic             bin_valid,
  output logic             step_up,
  output logic             step_down,
  output logic             err_jump,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {UNPRIMED, TRACKING} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   gray_p0;
  logic           vld_p0;
  logic [W-1:0]   gray_prev;
  logic [W-1:0]   bin_new;
  logic [W-1:0]   diff;
  logic           one_bit, multi_bit;
  logic           up_d, down_d, jump_d;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Stage A: capture the Gray word on the sample strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_p0 <= '0;
      vld_p0  <= 1'b0;
    end else if (clear) begin
      vld_p0  <= 1'b0;
    end else begin
      vld_p0  <= sample;
      if (sample) gray_p0 <= gray_in;
    end
  end

  // A single-bit Gray change is detected as a non-zero power of two in the XOR.
  always_comb begin
    bin_new   = gray2bin(gray_p0);
    diff      = gray_p0 ^ gray_prev;
    one_bit   = (diff != '0) && ((diff & (diff - 1'b1)) == '0);
    multi_bit = (diff != '0) && !one_bit;
    state_d   = state_q;
    up_d      = 1'b0;
    down_d    = 1'b0;
    jump_d    = 1'b0;
    if (clear) begin
      state_d = UNPRIMED;
    end else if (vld_p0) begin
      state_d = TRACKING;
      if (state_q == TRACKING) begin
        if (one_bit) begin
          if (bin_new == bin_out + 1'b1) up_d = 1'b1;
          else                           down_d = 1'b1;
        end else if (multi_bit) begin
          jump_d = 1'b1;
        end
      end
    end
  end

  // Stage B: register decoded value, flags and tracking reference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= UNPRIMED;
      bin_out   <= '0;
      gray_prev <= '0;
      bin_valid <= 1'b0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      err_jump  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      bin_valid <= vld_p0 & ~clear;
      step_up   <= up_d;
      step_down <= down_d;
      err_jump  <= jump_d;
      if (clear) begin
        err_cnt <= '0;
      end else if (vld_p0) begin
        bin_out   <= bin_new;
        gray_prev <= gray_p0;
        if (jump_d) err_cnt <= sat_inc(err_cnt);
      end
    end
  end

endmodule

// File: doc/gray_dec_tracker.md
Name: gray_dec_tracker

Overview:
- Gray-to-binary decoder with sample tracking; the decode-side counterpart of the team's binary-to-Gray converter.
- Captures a Gray-coded word (position encoder or Gray counter crossing a domain) on a sample strobe and decodes it to binary.
- Classifies each sample against the previous one as up-step, down-step, no change or illegal jump, and counts illegal jumps.
- Sits between Gray sources and binary-consuming logic.

Parameters:
W, 4, data width of gray_in and bin_out (legal range 2..16)
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
sample  input  1  capture strobe; gray_in is sampled on the rising edge where sample=1
gray_in  input  W  Gray-coded word, held stable by the source around the sampling edge
clear  input  1  synchronous clear of tracking state and error counter
bin_out  output  W  decoded binary value of the last processed sample
bin_valid  output  1  one-cycle pulse: bin_out and flags updated this cycle
step_up  output  1  with bin_valid: new = old+1 mod 2^W
step_down  output  1  with bin_valid: new = old-1 mod 2^W
err_jump  output  1  with bin_valid: Hamming distance between successive Gray samples >1
err_cnt  output  ERR_W  count of err_jump events, saturates at all-ones

Behaviour:
- One clock domain: clk. rst_n is asynchronous active-low.
- Reset (rst_n=0, asynchronous) drives all of the following to zero: bin_out, bin_valid, step_up, step_down, err_jump, err_cnt, the internal Gray register and the stage valid bit. State returns to UNPRIMED.
- Reset mid-pipeline discards any in-flight sample; no bin_valid is produced for it.
- Stage A, edge E0 with sample=1: gray_q <= gray_in; a_vld <= 1. Otherwise a_vld <= 0.
- Stage B, edge E1 with a_vld=1:
  - Decode: b[W-1] = g[W-1]; b[i] = b[i+1] XOR g[i].
  - Register bin_out and the flags; bin_valid=1 for exactly one cycle.
- Latency: sample at E0 gives bin_valid high in the cycle after E1 (2 edges).
- Throughput: sample may be high every cycle; each sample yields exactly one bin_valid pulse, in order.
- Flags are valid only while bin_valid=1 and are 0 in every other cycle.
- State machine (2 states):
  - UNPRIMED: first processed sample sets bin_out. step_up=step_down=err_jump=0. Store gray_prev and bin_prev, then go to TRACKING.
  - TRACKING: compute d = popcount(gray_q XOR gray_prev).
    - d=0: no flags.
    - d=1: step_up if bin_new == bin_prev+1 mod 2^W, else step_down. Wrap cases: all-ones -> 0 is step_up; 0 -> all-ones is step_down.
    - d>=2: err_jump=1; err_cnt increments unless at 2^ERR_W-1, where it holds. bin_out still takes the new decoded value and becomes the new reference.
  - step_up, step_down and err_jump are mutually exclusive.
- clear=1 at an edge:
  - Return to UNPRIMED, err_cnt <= 0, a_vld <= 0.
  - bin_out holds its value; no bin_valid that cycle.
  - clear has priority over sample and over the stage-B update in the same cycle.
- bin_out and err_cnt hold their values between bin_valid pulses.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle with sample pulses in flight -> all outputs 0 immediately; after release, no spurious bin_valid.
- Up count, W=4: samples 0000,0001,0011,0010,0110 back-to-back -> bin_out 0,1,2,3,4 on consecutive bin_valid pulses. First pulse has no flags; pulses 2-5 have step_up=1; err_cnt=0.
- Wrap and down: prime with 1000 (bin 15), then 0000 -> step_up, bin 0; then 1000 -> step_down, bin 15. Also 0001 -> 0000 gives step_down, bin 0.
- Illegal jump: 0000 then 0011 -> err_jump=1, bin_out=2, err_cnt=1. Then 0010 -> step_up, bin 3. Repeat jumps 300 times with ERR_W=8 -> err_cnt saturates at 255.
- Idle and hold: sample=0 for 20 cycles -> bin_valid stays 0 and bin_out is unchanged. Resampling the same word -> bin_valid=1 with all flags 0.
- Clear: after err_cnt=3, clear=1 together with sample=1 -> no bin_valid that cycle, err_cnt=0. The next sample 0101 gives bin 6 with no flags (UNPRIMED).
